// File: rtl/tile_map_renderer.sv
// -----------------------------------------------------------------------------
// tile_map_renderer
//   Pipelined pixel renderer for the Minesweeper board. Maps each scan
//   coordinate onto a board cell. It fetches the cell's sprite texel from an
//   external synchronous ROM with 1-cycle latency, and produces RGB565 with a
//   cursor border. The cursor position is latched once per frame.
//
//   Latency: an input sampled at edge k appears on rgb_o/rgb_valid_o after
//   edge k+3.
//     S1 (k)   : local coordinates, in-map test, cell/texel coordinates,
//                cursor-border hit
//     S2 (k+1) : tile resolution, sprite_addr_o registered
//     S2b(k+2) : override flags delayed while the ROM returns the texel
//     S3 (k+3) : rgb_o select
//
//   Optional feature macro: CURSOR_BLINK_EN
//     When this macro is defined, the cursor border blinks every BLINK_FRAMES
//     frames. When it is undefined, the border is always shown.
//
// Ports
//   vga_clk        pixel clock
//   rst_n          synchronous active-low reset
//   addr_h/addr_v  scan column/row (12 bit)
//   pix_valid_i    scan position is inside the active display
//   frame_start_i  1-cycle pulse on the first cycle of each frame
//   cursor_x_i/y_i selected cell (latched on frame_start_i)
//   map_i          cell contents, cell n=y*MAP_W+x at [n*CELL_BITS +: CELL_BITS]
//   map_shown_i    1 = cell uncovered
//   map_flag_i     1 = cell flagged
//   sprite_addr_o  {tile[3:0], local_y, local_x} to the sprite ROM
//   sprite_data_i  ROM texel, valid one cycle after sprite_addr_o
//   rgb_o          RGB565 output pixel
//   rgb_valid_o    pix_valid_i aligned with rgb_o
// -----------------------------------------------------------------------------
module tile_map_renderer #(
  parameter int unsigned MAP_W        = 8,
  parameter int unsigned MAP_H        = 8,
  parameter int unsigned CELL_LOG2    = 5,
  parameter int unsigned BORDER_W     = 2,
  parameter int unsigned ORG_X        = 192,
  parameter int unsigned ORG_Y        = 112,
  parameter int unsigned CELL_BITS    = 4,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic                              vga_clk,
  input  logic                              rst_n,
  input  logic [11:0]                       addr_h,
  input  logic [11:0]                       addr_v,
  input  logic                              pix_valid_i,
  input  logic                              frame_start_i,
  input  logic [3:0]                        cursor_x_i,
  input  logic [3:0]                        cursor_y_i,
  input  logic [CELL_BITS*MAP_W*MAP_H-1:0]  map_i,
  input  logic [MAP_W*MAP_H-1:0]            map_shown_i,
  input  logic [MAP_W*MAP_H-1:0]            map_flag_i,
  output logic [4+2*CELL_LOG2-1:0]          sprite_addr_o,
  input  logic [15:0]                       sprite_data_i,
  output logic [15:0]                       rgb_o,
  output logic                              rgb_valid_o
);

  localparam int unsigned    CELL_PX = 1 << CELL_LOG2;
  localparam logic [12:0]    MAP_PW  = 13'(MAP_W * CELL_PX);
  localparam logic [12:0]    MAP_PH  = 13'(MAP_H * CELL_PX);
  localparam logic [11:0]    ORG_X12 = 12'(ORG_X);
  localparam logic [11:0]    ORG_Y12 = 12'(ORG_Y);
  localparam logic [CELL_LOG2-1:0] B_LO = CELL_LOG2'(BORDER_W);
  localparam logic [CELL_LOG2-1:0] B_HI = CELL_LOG2'(CELL_PX - BORDER_W);
  localparam logic [CELL_BITS-1:0] MAX_GOOD = CELL_BITS'(9);
  localparam logic [3:0]     TILE_FLAG   = 4'd10;
  localparam logic [3:0]     TILE_HIDDEN = 4'd11;

  // ---------------------------------------------------------------------------
  // Frame-latched cursor and optional blink state
  // ---------------------------------------------------------------------------
  logic [3:0] r_cur_x;
  logic [3:0] r_cur_y;
  logic       w_blink_on;

  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      r_cur_x <= '0;
      r_cur_y <= '0;
    end else if (frame_start_i) begin
      r_cur_x <= cursor_x_i;
      r_cur_y <= cursor_y_i;
    end
  end

`ifdef CURSOR_BLINK_EN
  logic [15:0] r_blink_cnt;
  logic        r_blink_on;

  // blink_cnt counts frame pulses. Each wrap toggles the border. A new cursor
  // position restarts the sequence with the border visible, so a fresh
  // selection is shown at once.
  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else if (frame_start_i) begin
      if ((cursor_x_i != r_cur_x) || (cursor_y_i != r_cur_y)) begin
        r_blink_cnt <= '0;
        r_blink_on  <= 1'b1;
      end else if (r_blink_cnt == 16'(BLINK_FRAMES - 1)) begin
        r_blink_cnt <= '0;
        r_blink_on  <= ~r_blink_on;
      end else begin
        r_blink_cnt <= r_blink_cnt + 16'd1;
      end
    end
  end

  assign w_blink_on = r_blink_on;
`else
  assign w_blink_on = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // S1: coordinate mapping
  // ---------------------------------------------------------------------------
  logic [11:0]          w_loc_h;
  logic [11:0]          w_loc_v;
  logic                 w_in_map;
  logic [3:0]           w_cx;
  logic [3:0]           w_cy;
  logic [CELL_LOG2-1:0] w_lx;
  logic [CELL_LOG2-1:0] w_ly;
  logic                 w_border;
  logic                 w_cur_hit;

  // When the scan position is left of or above the board origin, the 12-bit
  // subtraction wraps to a large value. That value fails the range test, so
  // no separate sign check is needed.
  assign w_loc_h  = addr_h - ORG_X12;
  assign w_loc_v  = addr_v - ORG_Y12;
  assign w_in_map = pix_valid_i && ({1'b0, w_loc_h} < MAP_PW) && ({1'b0, w_loc_v} < MAP_PH);
  assign w_cx     = 4'(w_loc_h >> CELL_LOG2);
  assign w_cy     = 4'(w_loc_v >> CELL_LOG2);
  assign w_lx     = CELL_LOG2'(w_loc_h);
  assign w_ly     = CELL_LOG2'(w_loc_v);
  assign w_border = (w_lx < B_LO) || (w_lx >= B_HI) || (w_ly < B_LO) || (w_ly >= B_HI);

  // The cursor is compared against the latch value from before this edge. If
  // frame_start_i is high on this same edge, the pixel still sees the old
  // cursor. A latched cursor outside the board never matches an in-map cell,
  // so it highlights nothing.
  assign w_cur_hit = w_in_map && (w_cx == r_cur_x) && (w_cy == r_cur_y) && w_border && w_blink_on;

  logic                 r1_valid;
  logic                 r1_in_map;
  logic                 r1_cur_hit;
  logic [3:0]           r1_cx;
  logic [3:0]           r1_cy;
  logic [CELL_LOG2-1:0] r1_lx;
  logic [CELL_LOG2-1:0] r1_ly;

  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      r1_valid   <= 1'b0;
      r1_in_map  <= 1'b0;
      r1_cur_hit <= 1'b0;
      r1_cx      <= '0;
      r1_cy      <= '0;
      r1_lx      <= '0;
      r1_ly      <= '0;
    end else begin
      r1_valid   <= pix_valid_i;
      r1_in_map  <= w_in_map;
      r1_cur_hit <= w_cur_hit;
      r1_cx      <= w_cx;
      r1_cy      <= w_cy;
      r1_lx      <= w_lx;
      r1_ly      <= w_ly;
    end
  end

  // ---------------------------------------------------------------------------
  // S2: tile resolution
  // ---------------------------------------------------------------------------
  logic [8:0]                       w_idx;
  logic [MAP_W*MAP_H-1:0]           w_shown_vec;
  logic [MAP_W*MAP_H-1:0]           w_flag_vec;
  logic [CELL_BITS*MAP_W*MAP_H-1:0] w_cont_vec;
  logic [CELL_BITS-1:0]             w_content;
  logic                             w_shown;
  logic                             w_flag;
  logic [3:0]                       w_tile;
  logic                             w_bad;

  // The cell is selected with shifts rather than indexed selects. This keeps
  // the index width independent of the board size.
  assign w_idx       = 9'(r1_cy) * 9'(MAP_W) + 9'(r1_cx);
  assign w_shown_vec = map_shown_i >> w_idx;
  assign w_flag_vec  = map_flag_i >> w_idx;
  assign w_cont_vec  = map_i >> (13'(w_idx) * 13'(CELL_BITS));
  assign w_shown     = w_shown_vec[0];
  assign w_flag      = w_flag_vec[0];
  assign w_content   = CELL_BITS'(w_cont_vec);

  always_comb begin
    w_tile = 4'(w_content);
    w_bad  = 1'b0;
    if (w_flag) begin
      w_tile = TILE_FLAG;
    end else if (!w_shown) begin
      w_tile = TILE_HIDDEN;
    end else begin
      w_bad = (w_content > MAX_GOOD);
    end
  end

  logic r2_valid;
  logic r2_in_map;
  logic r2_cur_hit;
  logic r2_bad;

  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      r2_valid      <= 1'b0;
      r2_in_map     <= 1'b0;
      r2_cur_hit    <= 1'b0;
      r2_bad        <= 1'b0;
      sprite_addr_o <= '0;
    end else begin
      r2_valid      <= r1_valid;
      r2_in_map     <= r1_in_map;
      r2_cur_hit    <= r1_cur_hit;
      r2_bad        <= w_bad;
      sprite_addr_o <= {w_tile, r1_ly, r1_lx};
    end
  end

  // ---------------------------------------------------------------------------
  // S2b: hold the override flags while the ROM returns the texel
  // ---------------------------------------------------------------------------
  logic r3_valid;
  logic r3_in_map;
  logic r3_cur_hit;
  logic r3_bad;

  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      r3_valid   <= 1'b0;
      r3_in_map  <= 1'b0;
      r3_cur_hit <= 1'b0;
      r3_bad     <= 1'b0;
    end else begin
      r3_valid   <= r2_valid;
      r3_in_map  <= r2_in_map;
      r3_cur_hit <= r2_cur_hit;
      r3_bad     <= r2_bad;
    end
  end

  // ---------------------------------------------------------------------------
  // S3: colour select
  // ---------------------------------------------------------------------------
  logic [15:0] w_rgb;

  always_comb begin
    w_rgb = sprite_data_i;
    if (!r3_valid || !r3_in_map) begin
      w_rgb = '0;
    end else if (r3_cur_hit) begin
      w_rgb = '1;
    end else if (r3_bad) begin
      w_rgb = '0;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      rgb_o       <= '0;
      rgb_valid_o <= 1'b0;
    end else begin
      rgb_o       <= w_rgb;
      rgb_valid_o <= r3_valid;
    end
  end

endmodule

// File: tb/tb_tile_map_renderer.sv
module tb_tile_map_renderer;

  localparam int MW = 8;
  localparam int MH = 8;
  localparam int CP = 32;
  localparam int BW = 2;
  localparam int OX = 192;
  localparam int OY = 112;
  localparam int BF = 2;

  logic         vga_clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [11:0]  addr_h = '0;
  logic [11:0]  addr_v = '0;
  logic         pix_valid_i = 1'b0;
  logic         frame_start_i = 1'b0;
  logic [3:0]   cursor_x_i = '0;
  logic [3:0]   cursor_y_i = '0;
  logic [255:0] map_i = '0;
  logic [63:0]  map_shown_i = '0;
  logic [63:0]  map_flag_i = '0;
  logic [13:0]  sprite_addr_o;
  logic [15:0]  sprite_data_i = '0;
  logic [15:0]  rgb_o;
  logic         rgb_valid_o;

  tile_map_renderer #(
    .MAP_W(MW), .MAP_H(MH), .CELL_LOG2(5), .BORDER_W(BW), .ORG_X(OX), .ORG_Y(OY),
    .CELL_BITS(4), .BLINK_FRAMES(BF)
  ) u_dut (
    .vga_clk(vga_clk), .rst_n(rst_n), .addr_h(addr_h), .addr_v(addr_v),
    .pix_valid_i(pix_valid_i), .frame_start_i(frame_start_i),
    .cursor_x_i(cursor_x_i), .cursor_y_i(cursor_y_i),
    .map_i(map_i), .map_shown_i(map_shown_i), .map_flag_i(map_flag_i),
    .sprite_addr_o(sprite_addr_o), .sprite_data_i(sprite_data_i),
    .rgb_o(rgb_o), .rgb_valid_o(rgb_valid_o)
  );

  always #5 vga_clk = ~vga_clk;

  function automatic logic [15:0] rom_f(input logic [13:0] a);
    logic [31:0] t;
    t = 32'(a) * 32'd40503 + 32'd12345;
    return t[15:0];
  endfunction

  // Synchronous sprite ROM with one cycle of latency
  always @(posedge vga_clk) sprite_data_i <= rom_f(sprite_addr_o);

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected results indexed by the edge number at which the inputs were sampled
  logic        e_rst [8];
  logic        e_val [8];
  logic [15:0] e_rgb [8];
  logic [13:0] e_addr[8];
  logic        e_chk [8];

  // Reference state: latched cursor and frame pulses since the last restart
  int m_cx = 0;
  int m_cy = 0;
  int m_p  = 0;

  function automatic bit model_on();
`ifdef CURSOR_BLINK_EN
    return ((m_p / BF) % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic step(input bit rst, input int h, input int v, input bit valid,
                      input bit fs, input int cx, input int cy);
    int slot, lh, lv, ccx, ccy, lx, ly, n, content, tile, addr;
    int s0, s1, s3;
    bit inm, flag, shown, border, hit, bad, zero;
    logic [255:0] tmp;
    rst_n         = !rst;
    addr_h        = 12'(h);
    addr_v        = 12'(v);
    pix_valid_i   = valid;
    frame_start_i = fs;
    cursor_x_i    = 4'(cx);
    cursor_y_i    = 4'(cy);
    slot = (cyc + 1) % 8;
    e_rst[slot]  = rst;
    e_val[slot]  = 1'b0;
    e_rgb[slot]  = '0;
    e_addr[slot] = '0;
    e_chk[slot]  = 1'b0;
    if (rst) begin
      m_cx = 0; m_cy = 0; m_p = 0;
    end else begin
      lh  = (h - OX) & 4095;
      lv  = (v - OY) & 4095;
      inm = valid && (lh < MW * CP) && (lv < MH * CP);
      e_val[slot] = valid;
      if (inm) begin
        ccx = lh / CP; lx = lh % CP;
        ccy = lv / CP; ly = lv % CP;
        n = ccy * MW + ccx;
        flag  = map_flag_i[n];
        shown = map_shown_i[n];
        tmp   = map_i >> (n * 4);
        content = int'(tmp[3:0]);
        border = (lx < BW) || (lx >= CP - BW) || (ly < BW) || (ly >= CP - BW);
        hit  = border && (ccx == m_cx) && (ccy == m_cy) && model_on();
        tile = flag ? 10 : (!shown ? 11 : content);
        bad  = !flag && shown && (content > 9);
        addr = tile * 1024 + ly * 32 + lx;
        e_chk[slot]  = !bad;
        e_addr[slot] = 14'(addr);
        e_rgb[slot]  = hit ? 16'hFFFF : (bad ? 16'h0000 : rom_f(14'(addr)));
      end
      if (fs) begin
        if (cx != m_cx || cy != m_cy) begin
          m_cx = cx; m_cy = cy; m_p = 0;
        end else begin
          m_p++;
        end
      end
    end
    @(posedge vga_clk);
    #1;
    cyc++;
    s0 = cyc % 8;
    s1 = (cyc + 7) % 8;
    s3 = (cyc + 5) % 8;
    zero = e_rst[s0] || e_rst[s1] || e_rst[(cyc + 6) % 8] || e_rst[s3];
    if (zero) begin
      check("rgb_rst", 32'(rgb_o), 32'h0);
      check("valid_rst", 32'(rgb_valid_o), 32'h0);
    end else begin
      check("rgb", 32'(rgb_o), 32'(e_rgb[s3]));
      check("valid", 32'(rgb_valid_o), 32'(e_val[s3]));
    end
    if (e_rst[s0])
      check("addr_rst", 32'(sprite_addr_o), 32'h0);
    else if (!e_rst[s1] && e_chk[s1])
      check("sprite_addr", 32'(sprite_addr_o), 32'(e_addr[s1]));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic pix(input int cx, input int cy, input int lx, input int ly);
    step(0, OX + cx * CP + lx, OY + cy * CP + ly, 1, 0, 0, 0);
  endtask

  task automatic set_cell(input int n, input int content, input bit shown, input bit flag);
    map_i[n * 4 +: 4] = 4'(content);
    map_shown_i[n]    = shown;
    map_flag_i[n]     = flag;
  endtask

  task automatic rand_map();
    for (int i = 0; i < 8; i++) map_i[i * 32 +: 32] = $urandom();
    map_shown_i = {$urandom(), $urandom()};
    map_flag_i  = {$urandom(), $urandom()} & {$urandom(), $urandom()};
  endtask

  task automatic rand_step();
    int h, v;
    if ($urandom_range(9, 0) == 0) begin
      h = $urandom_range(4095, 0); v = $urandom_range(4095, 0);
    end else begin
      h = $urandom_range(OX + 300, OX - 40); v = $urandom_range(OY + 300, OY - 40);
    end
    step(0, h, v, $urandom_range(9, 0) != 0, $urandom_range(19, 0) == 0,
         $urandom_range(9, 0), $urandom_range(9, 0));
  endtask

  initial begin
    for (int i = 0; i < 8; i++) e_rst[i] = 1'b1;
    rand_map();

    // Reset, then release into a random stream
    for (int i = 0; i < 5; i++) step(1, OX + 40, OY + 40, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) rand_step();

    // Latency and tile lookup on a known cell
    idle(3);
    set_cell(3 * MW + 2, 5, 1'b1, 1'b0);
    step(0, OX, OY + 300, 0, 1, 0, 0);
    pix(2, 3, 10, 10);
    idle(4);

    // Tile priority: flagged and shown, hidden mine, shown bad content
    set_cell(4 * MW + 4, 3, 1'b1, 1'b1);
    set_cell(4 * MW + 5, 9, 1'b0, 1'b0);
    set_cell(4 * MW + 6, 12, 1'b1, 1'b0);
    idle(3);
    pix(4, 4, 16, 16);
    pix(5, 4, 16, 16);
    pix(6, 4, 16, 16);
    idle(4);

    // Cursor latch, mid-frame input change, off-board cursor
    step(0, 0, 0, 0, 1, 2, 3);
    pix(2, 3, 0, 15); pix(2, 3, 31, 15); pix(2, 3, 15, 15);
    pix(2, 3, 15, 0); pix(2, 3, 15, 31); pix(2, 3, 1, 30);
    step(0, OX + 64, OY + 96, 1, 0, 5, 5);
    pix(2, 3, 0, 15); pix(2, 3, 31, 31); pix(5, 5, 0, 0);
    step(0, OX + 64, OY + 96, 1, 1, 9, 0);
    pix(2, 3, 0, 15); pix(0, 0, 0, 0); pix(7, 0, 31, 0); pix(1, 0, 15, 0);
    idle(4);

    // Bounds and invalid pixels
    step(0, OX - 1, OY + 5, 1, 0, 0, 0);
    step(0, OX + 256, OY + 5, 1, 0, 0, 0);
    step(0, OX + 5, OY - 1, 1, 0, 0, 0);
    step(0, OX + 5, OY + 256, 1, 0, 0, 0);
    step(0, OX + 255, OY + 255, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, OX + 40, OY + 40, 0, 0, 0, 0);
    idle(4);

    // Per-frame border visibility with a steady cursor, then a cursor move
    step(0, 0, 0, 0, 1, 1, 1);
    for (int f = 0; f < 6; f++) begin
      pix(1, 1, 0, 10);
      step(0, 0, 0, 0, 1, 1, 1);
    end
    step(0, 0, 0, 0, 1, 1, 2);
    pix(1, 2, 0, 10);
    idle(4);

    // Random stream with map refreshes and one mid-frame reset
    for (int blk = 0; blk < 6; blk++) begin
      idle(3);
      rand_map();
      for (int i = 0; i < 100; i++) rand_step();
      if (blk == 2) begin
        for (int i = 0; i < 5; i++) step(1, OX + 20, OY + 20, 1, 0, 0, 0);
      end
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
